fft_peak_tracker: RTL
=====================

Name: fft_peak_tracker

Overview:
- Streaming post-processor on the fftmain output bus: consumes {re,im} bins framed by the FFT sync, computes |X|^2 per bin, and reports the strongest bin inside a programmable search window once per frame.
- Replaces the bench-side sqrt/peak scan with synthesizable logic for the spectrum path.
- Parametrised in FFT length, sample width and search window; detects framing errors.

Parameters:
- LGSIZE, 11, log2 of FFT length; frame = 2^LGSIZE bins.
- IW, 16, width of each signed re/im component.
- LO_BIN, 1, first bin searched; excludes DC by default.
- HI_BIN, 1023, last bin searched; LO_BIN <= HI_BIN < 2^LGSIZE.
- MW, 2*IW+1, magnitude-squared width, derived; not overridden.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ce  in  1  input bin valid, one bin per asserted cycle.
- i_result  in  2*IW  {re[2IW-1:IW], im[IW-1:0]}, two's complement.
- i_sync  in  1  high with bin 0 of a frame; qualified by i_ce.
- o_valid  out  1  one-cycle pulse: peak result valid.
- o_peak_bin  out  LGSIZE  bin index of the maximum.
- o_peak_mag  out  MW  re^2+im^2 of that bin, unsigned.
- o_frame_err  out  1  one-cycle pulse: i_sync arrived mid-frame.

Behaviour:
- Reset is synchronous and active-high on i_clk. All outputs are 0 after reset. State returns to WAIT_SYNC; the pipeline valid bits are cleared.
- State machine:
  - WAIT_SYNC: ignores bins until i_ce&&i_sync, then goes to SCAN with the bin counter at 0.
  - SCAN: the counter increments on each i_ce. When bin 2^LGSIZE-1 is accepted, the FSM goes to WAIT_SYNC, or stays in SCAN if the next i_ce carries i_sync.
- Frame error: i_ce&&i_sync while in SCAN with counter != 0 (i.e. not at the expected frame start).
  - Pulse o_frame_err.
  - Discard the partial frame; no o_valid is issued for it.
  - Restart the frame at bin 0 with that sample.
- Pipeline:
  - Advances every clock and carries a valid/bin/last tag; it does not stall on i_ce gaps.
  - S1 registers re, im, bin index and the in-window flag.
  - S2 registers re*re + im*im at full MW width, so there is no overflow. The most negative value squared is representable.
  - S3 performs the compare/update.
- Compare rule:
  - Only in-window bins (LO_BIN <= bin <= HI_BIN) are considered.
  - The first in-window bin of a frame loads unconditionally.
  - Later bins replace the stored peak only on strictly greater magnitude, so ties keep the lowest bin.
- Latency: the last bin is accepted at edge N; o_valid, o_peak_bin and o_peak_mag update at edge N+3. o_valid is high for exactly one cycle.
  - o_peak_* hold their value until the next report.
  - Back-to-back frames with no gap still yield one report per frame.
- Frame with no in-window bins: cannot occur under the parameter constraints; a parameter assertion checks this at elaboration.
- Reset mid-frame: the frame is dropped, with no report and no error pulse.

Optional Feature:
- Macro: FFT_PEAK_ENERGY_EN.
- Defined:
  - Adds output o_energy (MW+LGSIZE bits): the sum of |X|^2 over the in-window bins of the frame.
  - o_energy is valid with o_valid and is cleared at each frame start.
  - A frame error discards the partial sum.
- Undefined: the port and the accumulator are absent. All other behaviour is identical.

Decomposition:
- Package fft_pkg holds:
  - typedef state_t {WAIT_SYNC, SCAN};
  - function magsq_width(iw);
  - localparam defaults for LGSIZE and IW, shared with fftmain wrappers.
- Sub-module fft_magsq: two-stage re^2+im^2 pipeline with a valid/tag passthrough. It is reused later by the spectrum display path.

Test Plan:
- Single tone: LGSIZE=11, a 2048-sample sine at 25 cycles/frame, amplitude 300, through fftmain -> o_peak_bin=25, o_valid once per frame, o_frame_err=0. The mirror bin 2023 is excluded by HI_BIN=1023.
- Direct bins: all bins 0 except bin 100={-32768,0} and bin 7={0,5} -> o_peak_bin=100, o_peak_mag=2^30, with no overflow.
- Tie: bins 40 and 41 both {3,4} -> o_peak_bin=40, o_peak_mag=25. The DC bin {30000,0} is ignored because LO_BIN=1.
- Framing: i_sync asserted again at bin 500 -> o_frame_err pulse, no o_valid for that frame, the next full frame reports correctly. Random i_ce gaps do not change the results.
- Latency/back-to-back: two consecutive frames with no i_ce gaps -> o_valid exactly 3 edges after each last bin. A reset at bin 1000 yields no report.
- FFT_PEAK_ENERGY_EN: bins 1..4 = {1,0},{0,2},{2,2},{0,0}, all others 0 -> o_energy=13.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT spectrum path (fftmain wrappers and
// post-processors).
package fft_pkg;

  localparam int LGSIZE_DEF = 11;
  localparam int IW_DEF     = 16;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    SCAN      = 1'b1
  } state_t;

  // The extra bit keeps (-2^(iw-1))^2 + (-2^(iw-1))^2 representable.
  function automatic int magsq_width(input int iw);
    return 2 * iw + 1;
  endfunction

endpackage

// File: rtl/fft_peak_tracker_if.sv
// Bin stream from fftmain into the peak tracker: {re,im} bins framed by sync.
interface fft_peak_tracker_if import fft_pkg::*; #(
  parameter int IW = IW_DEF
);
  // i_ce is the valid strobe. There is no ready: the consumer takes every bin
  // on which i_ce is high, and i_sync/i_result are only meaningful with i_ce.
  logic            i_ce;
  logic [2*IW-1:0] i_result;
  logic            i_sync;

  modport master (output i_ce, output i_result, output i_sync);
  modport slave  (input  i_ce, input  i_result, input  i_sync);
endinterface

// File: rtl/fft_magsq.sv
// Two-stage re^2+im^2 pipeline with a valid/tag passthrough; the result is
// unsigned and full width, so no input value can overflow it.
module fft_magsq import fft_pkg::*; #(
  parameter  int IW = IW_DEF,
  parameter  int TW = 1,
  localparam int MW = magsq_width(IW)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  input  logic [IW-1:0] i_re,
  input  logic [IW-1:0] i_im,
  input  logic [TW-1:0] i_tag,
  output logic          o_valid,
  output logic [MW-1:0] o_mag,
  output logic [TW-1:0] o_tag
);

  logic signed [2*IW-1:0] w_re_x;
  logic signed [2*IW-1:0] w_im_x;
  logic signed [2*IW-1:0] r_re2;
  logic signed [2*IW-1:0] r_im2;
  logic                   r_v1;
  logic [TW-1:0]          r_tag1;

  assign w_re_x = {{IW{i_re[IW-1]}}, i_re};
  assign w_im_x = {{IW{i_im[IW-1]}}, i_im};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_v1    <= 1'b0;
      r_tag1  <= '0;
      r_re2   <= '0;
      r_im2   <= '0;
      o_valid <= 1'b0;
      o_tag   <= '0;
      o_mag   <= '0;
    end else begin
      r_v1    <= i_valid;
      r_tag1  <= i_tag;
      r_re2   <= w_re_x * w_re_x;
      r_im2   <= w_im_x * w_im_x;
      o_valid <= r_v1;
      o_tag   <= r_tag1;
      o_mag   <= {1'b0, r_re2} + {1'b0, r_im2};
    end
  end

endmodule

// File: rtl/fft_peak_tracker.sv
// Per-frame peak search over |X|^2 of fftmain bins inside [LO_BIN, HI_BIN].
// Define FFT_PEAK_ENERGY_EN to add o_energy, the in-window energy per frame.
module fft_peak_tracker import fft_pkg::*; #(
  parameter  int LGSIZE = LGSIZE_DEF,
  parameter  int IW     = IW_DEF,
  parameter  int LO_BIN = 1,
  parameter  int HI_BIN = 1023,
  localparam int MW     = magsq_width(IW)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  fft_peak_tracker_if.slave s_bin,
  output logic              o_valid,
  output logic [LGSIZE-1:0] o_peak_bin,
  output logic [MW-1:0]     o_peak_mag,
  output logic              o_frame_err,
`ifdef FFT_PEAK_ENERGY_EN
  output logic [MW+LGSIZE-1:0] o_energy,
`endif
  output state_t            o_dbg_state
);

  localparam int TW = LGSIZE + 3;
  localparam logic [LGSIZE-1:0] LO_L     = LGSIZE'(LO_BIN);
  localparam logic [LGSIZE-1:0] HI_L     = LGSIZE'(HI_BIN);
  localparam logic [LGSIZE-1:0] LAST_BIN = {LGSIZE{1'b1}};

  // A window that misses every bin would leave the report undefined.
  generate
    if (LO_BIN < 0 || LO_BIN > HI_BIN || HI_BIN >= (1 << LGSIZE)) begin : g_bad_window
      $error("fft_peak_tracker: need 0 <= LO_BIN <= HI_BIN < 2**LGSIZE");
    end
  endgenerate

  state_t            r_state;
  logic [LGSIZE-1:0] r_cnt;
  logic              r_s1_v;
  logic              r_s1_first;
  logic              r_s1_last;
  logic              r_s1_inwin;
  logic [LGSIZE-1:0] r_s1_bin;
  logic [IW-1:0]     r_s1_re;
  logic [IW-1:0]     r_s1_im;
  logic [LGSIZE-1:0] w_idx;
  logic              w_inwin;

  // A sync sample is always bin 0, whether it opens a frame or restarts one.
  assign w_idx   = s_bin.i_sync ? '0 : r_cnt;
  assign w_inwin = (w_idx >= LO_L) && (w_idx <= HI_L);
  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= WAIT_SYNC;
      r_cnt       <= '0;
      r_s1_v      <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_inwin  <= 1'b0;
      r_s1_bin    <= '0;
      r_s1_re     <= '0;
      r_s1_im     <= '0;
      o_frame_err <= 1'b0;
    end else begin
      r_s1_v      <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_inwin  <= w_inwin;
      r_s1_bin    <= w_idx;
      r_s1_re     <= s_bin.i_result[2*IW-1:IW];
      r_s1_im     <= s_bin.i_result[IW-1:0];
      o_frame_err <= 1'b0;
      if (s_bin.i_ce) begin
        if (s_bin.i_sync) begin
          // SCAN never holds counter 0, so any sync seen here is mid-frame.
          o_frame_err <= (r_state == SCAN);
          r_s1_v      <= 1'b1;
          r_s1_first  <= 1'b1;
          r_cnt       <= LGSIZE'(1);
          r_state     <= SCAN;
        end else if (r_state == SCAN) begin
          r_s1_v    <= 1'b1;
          r_s1_last <= (r_cnt == LAST_BIN);
          r_cnt     <= r_cnt + LGSIZE'(1);
          if (r_cnt == LAST_BIN) begin
            r_state <= WAIT_SYNC;
          end
        end
      end
    end
  end

  logic              w_m_v;
  logic [MW-1:0]     w_m_mag;
  logic [TW-1:0]     w_m_tag;
  logic [LGSIZE-1:0] w_t_bin;
  logic              w_t_inwin;
  logic              w_t_first;
  logic              w_t_last;

  fft_magsq #(
    .IW (IW),
    .TW (TW)
  ) u_magsq (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (r_s1_v),
    .i_re    (r_s1_re),
    .i_im    (r_s1_im),
    .i_tag   ({r_s1_bin, r_s1_inwin, r_s1_first, r_s1_last}),
    .o_valid (w_m_v),
    .o_mag   (w_m_mag),
    .o_tag   (w_m_tag)
  );

  assign {w_t_bin, w_t_inwin, w_t_first, w_t_last} = w_m_tag;

  logic              r_have;
  logic [LGSIZE-1:0] r_pk_bin;
  logic [MW-1:0]     r_pk_mag;
  logic              w_take;
  logic [LGSIZE-1:0] w_nxt_bin;
  logic [MW-1:0]     w_nxt_mag;

  // Strictly-greater replacement keeps the lowest bin on ties; the bin-0 tag
  // clears r_have, which also drops whatever a discarded partial frame left.
  assign w_take    = w_m_v && w_t_inwin &&
                     (w_t_first || !r_have || (w_m_mag > r_pk_mag));
  assign w_nxt_bin = w_take ? w_t_bin : r_pk_bin;
  assign w_nxt_mag = w_take ? w_m_mag : r_pk_mag;

`ifdef FFT_PEAK_ENERGY_EN
  logic [MW+LGSIZE-1:0] r_acc;
  logic [MW+LGSIZE-1:0] w_acc_base;
  logic [MW+LGSIZE-1:0] w_acc_add;
  logic [MW+LGSIZE-1:0] w_acc_nxt;

  assign w_acc_base = w_t_first ? '0 : r_acc;
  assign w_acc_add  = w_t_inwin ? {{LGSIZE{1'b0}}, w_m_mag} : '0;
  assign w_acc_nxt  = w_acc_base + w_acc_add;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc    <= '0;
      o_energy <= '0;
    end else if (w_m_v) begin
      r_acc <= w_acc_nxt;
      if (w_t_last) begin
        o_energy <= w_acc_nxt;
      end
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_have     <= 1'b0;
      r_pk_bin   <= '0;
      r_pk_mag   <= '0;
      o_valid    <= 1'b0;
      o_peak_bin <= '0;
      o_peak_mag <= '0;
    end else begin
      o_valid <= 1'b0;
      if (w_m_v) begin
        r_pk_bin <= w_nxt_bin;
        r_pk_mag <= w_nxt_mag;
        if (w_take) begin
          r_have <= 1'b1;
        end else if (w_t_first) begin
          r_have <= 1'b0;
        end
        if (w_t_last) begin
          o_valid    <= 1'b1;
          o_peak_bin <= w_nxt_bin;
          o_peak_mag <= w_nxt_mag;
        end
      end
    end
  end

endmodule
